// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
// Memory-op encoding, FSM states, and lane/size decode functions.
package load_store_unit_pkg;

   typedef enum logic [3:0] {
      LOAD_STORE_NONE,
      LOAD_BYTE,
      LOAD_HALF,
      LOAD_WORD,
      LOAD_BYTE_U,
      LOAD_HALF_U,
      STORE_BYTE,
      STORE_HALF,
      STORE_WORD
   } mem_op_t;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_RESP
   } lsu_state_t;

   typedef enum logic [1:0] {
      SIZE_BYTE,
      SIZE_HALF,
      SIZE_WORD
   } mem_size_t;

   function automatic logic is_load(mem_op_t op);
      return op inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD,
                        LOAD_BYTE_U, LOAD_HALF_U};
   endfunction

   function automatic logic is_store(mem_op_t op);
      return op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
   endfunction

   function automatic mem_size_t access_size(mem_op_t op);
      mem_size_t s;
      case (op)
         LOAD_BYTE, LOAD_BYTE_U, STORE_BYTE: s = SIZE_BYTE;
         LOAD_HALF, LOAD_HALF_U, STORE_HALF: s = SIZE_HALF;
         default:                            s = SIZE_WORD;
      endcase
      return s;
   endfunction

   function automatic logic is_misaligned(mem_op_t op, logic [1:0] lane);
      logic m;
      case (access_size(op))
         SIZE_HALF: m = lane[0];
         SIZE_WORD: m = (lane != 2'b00);
         default:   m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] byte_en(mem_op_t op, logic [1:0] lane);
      logic [3:0] be;
      case (access_size(op))
         SIZE_BYTE: be = 4'b0001 << lane;
         SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_data(mem_op_t op, logic [31:0] d);
      logic [31:0] r;
      case (access_size(op))
         SIZE_BYTE: r = {4{d[7:0]}};
         SIZE_HALF: r = {2{d[15:0]}};
         default:   r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load data lane select and sign/zero extension.
// Purely combinational; lane is the byte offset latched at accept.
module load_extend
   import load_store_unit_pkg::*;
(
   input  mem_op_t     mem_op,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      shifted = word >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = lane[1] ? word[31:16] : word[15:0];
      case (mem_op)
         LOAD_BYTE:   data = {{24{b[7]}}, b};
         LOAD_BYTE_U: data = {24'h0, b};
         LOAD_HALF:   data = {{16{h[15]}}, h};
         LOAD_HALF_U: data = {16'h0, h};
         default:     data = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer on a req/gnt/rvalid bus.
// Handles alignment checks, lane steering and bus timeout.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  mem_op_t     mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t       state_q, state_d;
   mem_op_t          op_q, op_d;
   logic [1:0]       lane_q, lane_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic [31:0]      bus_addr_q, bus_addr_d;
   logic [3:0]       bus_be_q, bus_be_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;
   logic             done_q, done_d;
   logic             mis_q, mis_d;
   logic             fault_q, fault_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [31:0]      ext_data;
   logic             timeout_hit;

   load_extend u_load_extend (
      .mem_op (op_q),
      .lane   (lane_q),
      .word   (bus_rdata),
      .data   (ext_data)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      mis_d       = 1'b0;
      fault_d     = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (req_valid && mem_op != LOAD_STORE_NONE) begin
               cnt_d = '0;
               if (is_misaligned(mem_op, addr[1:0])) begin
                  done_d = 1'b1;
                  mis_d  = 1'b1;
               end else begin
                  state_d     = LSU_REQ;
                  op_d        = mem_op;
                  lane_d      = addr[1:0];
                  bus_req_d   = 1'b1;
                  bus_we_d    = is_store(mem_op);
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = byte_en(mem_op, addr[1:0]);
                  bus_wdata_d = store_data(mem_op, wdata);
               end
            end
         end
         LSU_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus_gnt) begin
               bus_req_d = 1'b0;
               if (is_store(op_q)) begin
                  state_d = LSU_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LSU_RESP;
               end
            end else if (timeout_hit) begin
               state_d   = LSU_IDLE;
               bus_req_d = 1'b0;
               done_d    = 1'b1;
               fault_d   = 1'b1;
            end
         end
         LSU_RESP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus_rvalid) begin
               state_d = LSU_IDLE;
               rdata_d = ext_data;
               done_d  = 1'b1;
            end else if (timeout_hit) begin
               state_d = LSU_IDLE;
               done_d  = 1'b1;
               fault_d = 1'b1;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LSU_IDLE;
         op_q        <= LOAD_STORE_NONE;
         lane_q      <= 2'b00;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         done_q      <= 1'b0;
         mis_q       <= 1'b0;
         fault_q     <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         done_q      <= done_d;
         mis_q       <= mis_d;
         fault_q     <= fault_d;
         rdata_q     <= rdata_d;
      end
   end

   assign busy       = (state_q != LSU_IDLE);
   assign req_ready  = (state_q == LSU_IDLE);
   assign done       = done_q;
   assign misaligned = mis_q;
   assign fault      = fault_q;
   assign rdata      = rdata_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: default-timeout instance A
// plus a short-timeout instance B for the fault path.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   mem_op_t     mem_op = LOAD_STORE_NONE;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] bus_rdata = '0;

   logic        req_valid_a = 1'b0, gnt_a = 1'b0, rvalid_a = 1'b0;
   logic        req_ready_a, busy_a, done_a, mis_a, fault_a;
   logic        bus_req_a, bus_we_a;
   logic [31:0] rdata_a, bus_addr_a, bus_wdata_a;
   logic [3:0]  bus_be_a;

   logic        req_valid_b = 1'b0, gnt_b = 1'b0, rvalid_b = 1'b0;
   logic        req_ready_b, busy_b, done_b, mis_b, fault_b;
   logic        bus_req_b, bus_we_b;
   logic [31:0] rdata_b, bus_addr_b, bus_wdata_b;
   logic [3:0]  bus_be_b;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit u_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_a), .req_ready(req_ready_a),
      .mem_op(mem_op), .addr(addr), .wdata(wdata),
      .busy(busy_a), .done(done_a), .rdata(rdata_a),
      .misaligned(mis_a), .fault(fault_a),
      .bus_req(bus_req_a), .bus_we(bus_we_a),
      .bus_addr(bus_addr_a), .bus_be(bus_be_a),
      .bus_wdata(bus_wdata_a), .bus_gnt(gnt_a),
      .bus_rvalid(rvalid_a), .bus_rdata(bus_rdata)
   );

   load_store_unit #(.TIMEOUT_CYCLES(4)) u_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_b), .req_ready(req_ready_b),
      .mem_op(mem_op), .addr(addr), .wdata(wdata),
      .busy(busy_b), .done(done_b), .rdata(rdata_b),
      .misaligned(mis_b), .fault(fault_b),
      .bus_req(bus_req_b), .bus_we(bus_we_b),
      .bus_addr(bus_addr_b), .bus_be(bus_be_b),
      .bus_wdata(bus_wdata_b), .bus_gnt(gnt_b),
      .bus_rvalid(rvalid_b), .bus_rdata(bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(); tick();
      chk("rst_req_ready", {31'b0, req_ready_a}, 32'd1);
      chk("rst_busy",      {31'b0, busy_a},      32'd0);
      chk("rst_done",      {31'b0, done_a},      32'd0);
      chk("rst_bus_req",   {31'b0, bus_req_a},   32'd0);
      chk("rst_rdata",     rdata_a,              32'h0);
      chk("rst_bus_addr",  bus_addr_a,           32'h0);
      chk("rst_bus_be",    {28'b0, bus_be_a},    32'h0);
      chk("rst_bus_wdata", bus_wdata_a,          32'h0);
      reset = 1'b0;

      // SB 0x1003, gnt at T+1, done at T+2
      tick();
      req_valid_a = 1'b1; mem_op = STORE_BYTE;
      addr = 32'h1003; wdata = 32'h0000_00A5;
      tick();
      req_valid_a = 1'b0;
      chk("sb_req",   {31'b0, bus_req_a}, 32'd1);
      chk("sb_we",    {31'b0, bus_we_a},  32'd1);
      chk("sb_addr",  bus_addr_a,         32'h1000);
      chk("sb_be",    {28'b0, bus_be_a},  32'h8);
      chk("sb_wdata", bus_wdata_a,        32'hA5A5A5A5);
      chk("sb_busy",  {31'b0, busy_a},    32'd1);
      chk("sb_done1", {31'b0, done_a},    32'd0);
      gnt_a = 1'b1;
      tick();
      gnt_a = 1'b0;
      chk("sb_done2",   {31'b0, done_a},    32'd1);
      chk("sb_req_off", {31'b0, bus_req_a}, 32'd0);
      chk("sb_ready",   {31'b0, req_ready_a}, 32'd1);
      tick();
      chk("sb_done_pulse", {31'b0, done_a}, 32'd0);

      // LB then LBU at 0x2002 on word 0x0080_0000
      for (int k = 0; k < 2; k++) begin
         req_valid_a = 1'b1; addr = 32'h2002;
         mem_op = (k == 0) ? LOAD_BYTE : LOAD_BYTE_U;
         tick();
         req_valid_a = 1'b0;
         chk("lb_req", {31'b0, bus_req_a}, 32'd1);
         chk("lb_we",  {31'b0, bus_we_a},  32'd0);
         chk("lb_be",  {28'b0, bus_be_a},  32'h4);
         gnt_a = 1'b1;
         tick();
         gnt_a = 1'b0;
         chk("lb_req_off", {31'b0, bus_req_a}, 32'd0);
         chk("lb_busy",    {31'b0, busy_a},    32'd1);
         chk("lb_done_t2", {31'b0, done_a},    32'd0);
         rvalid_a = 1'b1; bus_rdata = 32'h0080_0000;
         tick();
         rvalid_a = 1'b0; bus_rdata = 32'h0;
         chk("lb_done", {31'b0, done_a}, 32'd1);
         chk("lb_rdata", rdata_a,
             (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         tick();
      end

      // LH 0x3001: misaligned, no bus activity
      req_valid_a = 1'b1; mem_op = LOAD_HALF; addr = 32'h3001;
      tick();
      req_valid_a = 1'b0;
      chk("mis_done",  {31'b0, done_a},      32'd1);
      chk("mis_flag",  {31'b0, mis_a},       32'd1);
      chk("mis_req",   {31'b0, bus_req_a},   32'd0);
      chk("mis_ready", {31'b0, req_ready_a}, 32'd1);
      chk("mis_rdata", rdata_a,              32'h0000_0080);
      tick();
      chk("mis_pulse", {31'b0, mis_a},     32'd0);
      chk("mis_req2",  {31'b0, bus_req_a}, 32'd0);

      // LW with gnt held off for 5 cycles
      req_valid_a = 1'b1; mem_op = LOAD_WORD; addr = 32'h4008;
      tick();
      req_valid_a = 1'b0; addr = 32'hFFFF_FFFF;
      for (int c = 0; c < 5; c++) begin
         chk("lw_req",  {31'b0, bus_req_a}, 32'd1);
         chk("lw_addr", bus_addr_a,         32'h4008);
         chk("lw_be",   {28'b0, bus_be_a},  32'hF);
         chk("lw_busy", {31'b0, busy_a},    32'd1);
         tick();
      end
      gnt_a = 1'b1;
      tick();
      gnt_a = 1'b0;
      chk("lw_busy_resp", {31'b0, busy_a}, 32'd1);
      rvalid_a = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      tick();
      rvalid_a = 1'b0; bus_rdata = 32'h0;
      chk("lw_done",  {31'b0, done_a}, 32'd1);
      chk("lw_rdata", rdata_a,         32'hDEAD_BEEF);
      chk("lw_fault", {31'b0, fault_a}, 32'd0);
      tick();
      chk("lw_hold", rdata_a, 32'hDEAD_BEEF);

      // Timeout on instance B (TIMEOUT_CYCLES=4)
      req_valid_b = 1'b1; mem_op = LOAD_WORD; addr = 32'h5000;
      tick();
      req_valid_b = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("to_req",   {31'b0, bus_req_b}, 32'd1);
         chk("to_fault", {31'b0, fault_b},   32'd0);
         tick();
      end
      chk("to_fault_hit", {31'b0, fault_b},   32'd1);
      chk("to_done_hit",  {31'b0, done_b},    32'd1);
      chk("to_req_off",   {31'b0, bus_req_b}, 32'd0);
      chk("to_busy_off",  {31'b0, busy_b},    32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("to_fault_once", {31'b0, fault_b},   32'd0);
         chk("to_req_after",  {31'b0, bus_req_b}, 32'd0);
      end

      // SW after the timeout completes normally
      req_valid_b = 1'b1; mem_op = STORE_WORD;
      addr = 32'h0000_0040; wdata = 32'h1234_5678;
      tick();
      req_valid_b = 1'b0;
      chk("sw_be",    {28'b0, bus_be_b}, 32'hF);
      chk("sw_wdata", bus_wdata_b,       32'h1234_5678);
      chk("sw_we",    {31'b0, bus_we_b}, 32'd1);
      gnt_b = 1'b1;
      tick();
      gnt_b = 1'b0;
      chk("sw_done",  {31'b0, done_b},  32'd1);
      chk("sw_fault", {31'b0, fault_b}, 32'd0);
      tick();

      // Reset while A is in RESP, then a stray rvalid
      req_valid_a = 1'b1; mem_op = LOAD_WORD; addr = 32'h6000;
      tick();
      req_valid_a = 1'b0;
      gnt_a = 1'b1;
      tick();
      gnt_a = 1'b0;
      chk("rr_in_resp", {31'b0, busy_a}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_busy",  {31'b0, busy_a},    32'd0);
      chk("rr_req",   {31'b0, bus_req_a}, 32'd0);
      chk("rr_rdata", rdata_a,            32'h0);
      rvalid_a = 1'b1; bus_rdata = 32'hCAFE_F00D;
      tick();
      rvalid_a = 1'b0; bus_rdata = 32'h0;
      chk("rr_no_done", {31'b0, done_a},      32'd0);
      chk("rr_rdata2",  rdata_a,              32'h0);
      chk("rr_ready",   {31'b0, req_ready_a}, 32'd1);

      // LOAD_STORE_NONE is ignored
      req_valid_a = 1'b1; mem_op = LOAD_STORE_NONE; addr = 32'h7000;
      tick();
      req_valid_a = 1'b0;
      chk("none_done", {31'b0, done_a},    32'd0);
      chk("none_req",  {31'b0, bus_req_a}, 32'd0);
      chk("none_busy", {31'b0, busy_a},    32'd0);
      tick();
      chk("none_done2", {31'b0, done_a},   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
